// File: rtl/l1_cache_if.sv
// Bundles the core-side word port and the memory-side line port of l1_cache.
// Handshake: a core request (mem_read/mem_write) is held until the cycle with
// mem_resp=1; a memory request (pmem_read/pmem_write) is held, with stable
// address and data, until the cycle with the one-cycle pmem_resp pulse.
interface l1_cache_if;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         hit;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  // master: the core plus the L2/memory side; slave: the cache itself
  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, hit,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, hit,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate L1 cache, 32-bit words, 256-bit lines.
// Define L1_CACHE_WRITE_EN for the data-port build; without it the cache is read-only.
module l1_cache #(
  parameter int SETS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  l1_cache_if.slave  bus,
  output logic [1:0] dbg_state
);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 27 - IDXW;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              missed_q, missed_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;
  logic [TAGW-1:0]   tag_q  [SETS];
  logic [TAGW-1:0]   tag_d  [SETS];
  logic [255:0]      data_q [SETS];
  logic [255:0]      data_d [SETS];
  logic [31:0]       req_addr_q, req_addr_d;

  logic [IDXW-1:0]   cur_idx, miss_idx;
  logic [TAGW-1:0]   cur_tag, miss_tag;
  logic [2:0]        cur_word;
  logic              req, is_write, tag_hit;

  logic              mem_resp, hit, pmem_read, pmem_write;
  logic [31:0]       mem_rdata, pmem_address;
  logic [255:0]      pmem_wdata;

  assign cur_idx  = bus.mem_address[4+IDXW:5];
  assign cur_tag  = bus.mem_address[31:5+IDXW];
  assign cur_word = bus.mem_address[4:2];
  // The miss is serviced from the address captured at miss time, so the
  // memory-side strobes stay stable even if the core drops its request.
  assign miss_idx = req_addr_q[4+IDXW:5];
  assign miss_tag = req_addr_q[31:5+IDXW];

  assign req      = bus.mem_read | bus.mem_write;
  assign is_write = bus.mem_write;
  assign tag_hit  = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

`ifdef L1_CACHE_WRITE_EN
  logic [255:0] merged;
  logic         unused_bits;
  assign unused_bits = ^bus.mem_address[1:0];
`else
  logic         unused_bits;
  assign unused_bits = ^{bus.mem_address[1:0], bus.mem_wdata, bus.mem_byte_enable};
`endif

  always_comb begin
    state_d      = state_q;
    missed_d     = missed_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    req_addr_d   = req_addr_q;
    mem_resp     = 1'b0;
    hit          = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
`ifdef L1_CACHE_WRITE_EN
    merged       = data_q[cur_idx];
`endif

    case (state_q)
      S_IDLE: begin
        missed_d = 1'b0;
        if (req) begin
`ifdef L1_CACHE_WRITE_EN
          if (tag_hit) begin
`else
          if (tag_hit || is_write) begin
`endif
            mem_resp  = 1'b1;
            hit       = ~missed_q;
            mem_rdata = tag_hit ? data_q[cur_idx][{cur_word, 5'b00000} +: 32] : '0;
`ifdef L1_CACHE_WRITE_EN
            if (is_write) begin
              for (int b = 0; b < 4; b++) begin
                if (bus.mem_byte_enable[b]) begin
                  merged[{cur_word, b[1:0], 3'b000} +: 8] = bus.mem_wdata[b*8 +: 8];
                end
              end
              data_d[cur_idx]  = merged;
              dirty_d[cur_idx] = 1'b1;
            end
`endif
          end else begin
            missed_d   = 1'b1;
            req_addr_d = bus.mem_address;
`ifdef L1_CACHE_WRITE_EN
            state_d = (valid_q[cur_idx] && dirty_q[cur_idx]) ? S_WRITEBACK : S_FILL;
`else
            state_d = S_FILL;
`endif
          end
        end
      end

`ifdef L1_CACHE_WRITE_EN
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[miss_idx], miss_idx, 5'b00000};
        pmem_wdata   = data_q[miss_idx];
        missed_d     = missed_q & req;
        if (bus.pmem_resp) begin
          state_d = S_FILL;
        end
      end
`endif

      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag, miss_idx, 5'b00000};
        missed_d     = missed_q & req;
        if (bus.pmem_resp) begin
          data_d[miss_idx]  = bus.pmem_rdata;
          tag_d[miss_idx]   = miss_tag;
          valid_d[miss_idx] = 1'b1;
          dirty_d[miss_idx] = 1'b0;
          state_d           = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      missed_q <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      state_q  <= state_d;
      missed_q <= missed_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
    end
  end

  // Tag/data storage and the captured miss address are qualified by valid_q
  // and the FSM, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q      <= tag_d;
    data_q     <= data_d;
    req_addr_q <= req_addr_d;
  end

  assign bus.mem_resp     = mem_resp;
  assign bus.hit          = hit;
  assign bus.mem_rdata    = mem_rdata;
  assign bus.pmem_read    = pmem_read;
  assign bus.pmem_address = pmem_address;
  assign bus.pmem_wdata   = pmem_wdata;
`ifdef L1_CACHE_WRITE_EN
  assign bus.pmem_write   = pmem_write;
`else
  assign bus.pmem_write   = 1'b0;
`endif
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: directed scenarios plus randomized accesses
// compared against a line-level cache/memory model.
module tb_l1_cache;
  localparam int SETS = 8;
`ifdef L1_CACHE_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  l1_cache_if bus ();

  l1_cache #(.SETS(SETS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q [$];

  // ---------------- memory contents ----------------
  logic [255:0] env_mem [logic [26:0]];
  logic [255:0] mdl_mem [logic [26:0]];

  function automatic logic [255:0] init_line(input logic [26:0] line);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) begin
      r[w*32 +: 32] = ({5'b0, line} * 32'h9E37_79B9) ^ (w * 32'h0101_0101) ^ 32'h5A5A_0000;
    end
    return r;
  endfunction

  function automatic logic [255:0] env_get(input logic [26:0] line);
    return env_mem.exists(line) ? env_mem[line] : init_line(line);
  endfunction

  function automatic logic [255:0] mdl_get(input logic [26:0] line);
    return mdl_mem.exists(line) ? mdl_mem[line] : init_line(line);
  endfunction

  // ---------------- reference model ----------------
  bit           m_valid [SETS];
  bit           m_dirty [SETS];
  logic [26:0]  m_line  [SETS];
  logic [255:0] m_data  [SETS];

  logic         e_hit, e_wb;
  logic [31:0]  e_rdata, e_wb_addr;
  logic [255:0] e_wb_data;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
  endtask

  task automatic model_access(input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] be);
    logic [26:0] line;
    int set, w;
    line = addr[31:5];
    set  = int'(line % SETS);
    w    = int'(addr[4:2]);
    e_wb = 1'b0;
    e_rdata = '0;
    if (!WR_EN && wr) begin
      e_hit = 1'b1;
      return;
    end
    e_hit = m_valid[set] && (m_line[set] == line);
    if (!e_hit) begin
      if (m_valid[set] && m_dirty[set]) begin
        e_wb      = 1'b1;
        e_wb_addr = {m_line[set], 5'b0};
        e_wb_data = m_data[set];
        mdl_mem[m_line[set]] = m_data[set];
      end
      m_data[set]  = mdl_get(line);
      m_line[set]  = line;
      m_valid[set] = 1'b1;
      m_dirty[set] = 1'b0;
    end
    e_rdata = m_data[set][w*32 +: 32];
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) m_data[set][w*32 + b*8 +: 8] = wd[b*8 +: 8];
      end
      m_dirty[set] = 1'b1;
    end
  endtask

  // ---------------- driver: core requester + memory responder ----------------
  int           t_resp_cyc, t_wb_cyc, t_fill_cyc, t_first_wb, t_first_fill, t_bad, t_late;
  logic         t_hit;
  logic [31:0]  t_rdata, t_wb_addr, t_fill_addr;
  logic [255:0] t_wb_data;

  task automatic drive_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] be,
                              input int lat, input int drop_at);
    int cyc = 0;
    int mcnt = 0;
    int tail_end = -1;
    bit done = 1'b0;
    bit driven;
    t_resp_cyc = -1; t_wb_cyc = 0; t_fill_cyc = 0; t_first_wb = -1; t_first_fill = -1;
    t_bad = 0; t_late = 0; t_hit = 1'b0; t_rdata = '0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      driven = !(drop_at >= 0 && cyc >= drop_at);
      bus.mem_read        = driven ? rd : 1'b0;
      bus.mem_write       = driven ? wr : 1'b0;
      bus.mem_address     = addr;
      bus.mem_wdata       = wd;
      bus.mem_byte_enable = be;
      #1;
      if (bus.pmem_read && bus.pmem_write) t_bad++;
      if (bus.pmem_write) begin
        if (mcnt == 0) begin
          t_wb_addr = bus.pmem_address;
          t_wb_data = bus.pmem_wdata;
          if (t_first_wb < 0) t_first_wb = cyc;
        end else if (bus.pmem_address !== t_wb_addr || bus.pmem_wdata !== t_wb_data) begin
          t_bad++;
        end
        t_wb_cyc++;
        mcnt++;
        if (mcnt == lat) begin
          bus.pmem_resp = 1'b1;
          env_mem[t_wb_addr[31:5]] = bus.pmem_wdata;
          mcnt = 0;
        end
      end else if (bus.pmem_read) begin
        if (mcnt == 0) begin
          t_fill_addr = bus.pmem_address;
          if (t_first_fill < 0) t_first_fill = cyc;
        end else if (bus.pmem_address !== t_fill_addr) begin
          t_bad++;
        end
        t_fill_cyc++;
        mcnt++;
        if (mcnt == lat) begin
          bus.pmem_rdata = env_get(t_fill_addr[31:5]);
          bus.pmem_resp  = 1'b1;
          mcnt = 0;
          if (drop_at >= 0) tail_end = cyc + 2;
        end
      end
      if (bus.mem_resp) begin
        if (driven && t_resp_cyc < 0) begin
          t_resp_cyc = cyc;
          t_hit      = bus.hit;
          t_rdata    = bus.mem_rdata;
        end else begin
          t_late++;
        end
      end
      if (drop_at < 0 && t_resp_cyc >= 0) done = 1'b1;
      if (cyc == tail_end) done = 1'b1;
      cyc++;
    end
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.pmem_resp = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.mem_resp, bus.hit, bus.pmem_read, bus.pmem_write} !== 4'b0000)
      $display("FAIL reset_outputs: got %b, expected 0000",
               {bus.mem_resp, bus.hit, bus.pmem_read, bus.pmem_write});
    else n_pass++;
    n_checks++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d, expected 0", dbg_state);
    else n_pass++;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_clean_miss();
    logic [255:0] l;
    l = init_line(27'd2);
    l[31:0]  = 32'hDEAD_BEEF;
    l[63:32] = 32'hAABB_CCDD;
    env_mem[27'd2] = l;
    mdl_mem[27'd2] = l;
    model_access(1'b0, 32'h40, '0, '0);
    drive_access(1'b1, 1'b0, 32'h40, '0, '0, 3, -1);
    n_checks++;
    if (t_fill_cyc !== 3) $display("FAIL miss_fill_cycles: got %0d, expected 3", t_fill_cyc); else n_pass++;
    n_checks++;
    if (t_fill_addr !== 32'h40) $display("FAIL miss_fill_addr: got %h, expected 00000040", t_fill_addr); else n_pass++;
    n_checks++;
    if (t_resp_cyc !== 4) $display("FAIL miss_latency: got %0d, expected 4", t_resp_cyc); else n_pass++;
    n_checks++;
    if (t_hit !== 1'b0) $display("FAIL miss_hit: got %b, expected 0", t_hit); else n_pass++;
    n_checks++;
    if (t_rdata !== 32'hDEAD_BEEF) $display("FAIL miss_rdata: got %h, expected deadbeef", t_rdata); else n_pass++;
    model_access(1'b0, 32'h40, '0, '0);
    drive_access(1'b1, 1'b0, 32'h40, '0, '0, 3, -1);
    n_checks++;
    if (t_resp_cyc !== 0 || t_hit !== 1'b1 || t_fill_cyc !== 0)
      $display("FAIL reread_hit: got cyc=%0d hit=%b fills=%0d, expected cyc=0 hit=1 fills=0",
               t_resp_cyc, t_hit, t_fill_cyc);
    else n_pass++;
    model_access(1'b0, 32'h64, '0, '0);
    drive_access(1'b1, 1'b0, 32'h64, '0, '0, 1, -1);
    n_checks++;
    if (t_resp_cyc !== 2 || t_rdata !== e_rdata)
      $display("FAIL miss_lat1: got cyc=%0d data=%h, expected cyc=2 data=%h", t_resp_cyc, t_rdata, e_rdata);
    else n_pass++;
  endtask

  task automatic test_write_merge();
    logic [31:0] want;
    model_access(1'b1, 32'h44, 32'h1122_3344, 4'b0101);
    drive_access(1'b0, 1'b1, 32'h44, 32'h1122_3344, 4'b0101, 1, -1);
    n_checks++;
    if (t_resp_cyc !== 0 || t_hit !== 1'b1)
      $display("FAIL write_hit: got cyc=%0d hit=%b, expected cyc=0 hit=1", t_resp_cyc, t_hit);
    else n_pass++;
    want = WR_EN ? 32'hAA22_CC44 : 32'hAABB_CCDD;
    model_access(1'b0, 32'h44, '0, '0);
    drive_access(1'b1, 1'b0, 32'h44, '0, '0, 1, -1);
    n_checks++;
    if (t_rdata !== want) $display("FAIL write_merge: got %h, expected %h", t_rdata, want); else n_pass++;
  endtask

  task automatic test_dirty_evict();
    int want_cyc;
    model_access(1'b0, 32'h144, '0, '0);
    drive_access(1'b1, 1'b0, 32'h144, '0, '0, 2, -1);
    want_cyc = e_wb ? 5 : 3;
    n_checks++;
    if (t_wb_cyc !== (WR_EN ? 2 : 0)) $display("FAIL evict_wb_cycles: got %0d, expected %0d", t_wb_cyc, WR_EN ? 2 : 0);
    else n_pass++;
    if (e_wb) begin
      n_checks++;
      if (t_wb_addr !== 32'h40 || t_wb_data !== e_wb_data)
        $display("FAIL evict_wb_line: got addr=%h data=%h, expected addr=00000040 data=%h", t_wb_addr, t_wb_data, e_wb_data);
      else n_pass++;
      n_checks++;
      if (!(t_first_wb >= 0 && t_first_wb < t_first_fill))
        $display("FAIL evict_order: got wb@%0d fill@%0d, expected wb before fill", t_first_wb, t_first_fill);
      else n_pass++;
    end
`ifdef L1_CACHE_WRITE_EN
    n_checks++;
    if (t_wb_data[63:32] !== 32'hAA22_CC44) $display("FAIL evict_merged_word: got %h, expected aa22cc44", t_wb_data[63:32]);
    else n_pass++;
`endif
    n_checks++;
    if (t_fill_addr !== 32'h140 || t_resp_cyc !== want_cyc || t_hit !== 1'b0 || t_rdata !== e_rdata)
      $display("FAIL evict_fill: got addr=%h cyc=%0d hit=%b data=%h, expected addr=00000140 cyc=%0d hit=0 data=%h",
               t_fill_addr, t_resp_cyc, t_hit, t_rdata, want_cyc, e_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_during_fill();
    bit seen = 1'b0;
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h1040;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.pmem_read) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL rst_fill_start: got no pmem_read, expected pmem_read within 20 cycles"); else n_pass++;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0)
      $display("FAIL rst_abandon: got pmem_read=%b pmem_write=%b, expected 0 0", bus.pmem_read, bus.pmem_write);
    else n_pass++;
    reset_n = 1'b1;
    bus.mem_read = 1'b0;
    model_reset();
    model_access(1'b0, 32'h40, '0, '0);
    drive_access(1'b1, 1'b0, 32'h40, '0, '0, 2, -1);
    n_checks++;
    if (t_hit !== 1'b0 || t_fill_cyc !== 2 || t_resp_cyc !== 3 || t_rdata !== e_rdata)
      $display("FAIL rst_remiss: got hit=%b fills=%0d cyc=%0d data=%h, expected hit=0 fills=2 cyc=3 data=%h",
               t_hit, t_fill_cyc, t_resp_cyc, t_rdata, e_rdata);
    else n_pass++;
  endtask

  task automatic test_drop();
    model_access(1'b0, 32'h2C8, '0, '0);
    drive_access(1'b1, 1'b0, 32'h2C8, '0, '0, 3, 2);
    n_checks++;
    if (t_late !== 0 || t_resp_cyc !== -1 || t_fill_cyc !== 3)
      $display("FAIL drop_no_resp: got late=%0d cyc=%0d fills=%0d, expected late=0 cyc=-1 fills=3",
               t_late, t_resp_cyc, t_fill_cyc);
    else n_pass++;
    model_access(1'b0, 32'h2C8, '0, '0);
    drive_access(1'b1, 1'b0, 32'h2C8, '0, '0, 1, -1);
    n_checks++;
    if (t_resp_cyc !== 0 || t_hit !== 1'b1 || t_rdata !== e_rdata)
      $display("FAIL drop_then_hit: got cyc=%0d hit=%b data=%h, expected cyc=0 hit=1 data=%h",
               t_resp_cyc, t_hit, t_rdata, e_rdata);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] addr, wd;
    logic [3:0]  be;
    logic        rd, wr;
    int          lat, want_cyc;
    for (int i = 0; i < 250; i++) begin
      addr = {($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, 26'd0, 5'd0} |
             {22'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      wr  = ($urandom_range(0, 2) == 0);
      rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      be  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      lat = $urandom_range(1, 3);
      model_access(wr, addr, wd, be);
      if (!wr) exp_q.push_back(e_rdata);
      drive_access(rd, wr, addr, wd, be, lat, -1);
      want_cyc = e_hit ? 0 : 1 + lat + (e_wb ? lat : 0);
      n_checks++;
      if (t_resp_cyc !== want_cyc || t_hit !== e_hit)
        $display("FAIL rand_timing: addr=%h got cyc=%0d hit=%b, expected cyc=%0d hit=%b",
                 addr, t_resp_cyc, t_hit, want_cyc, e_hit);
      else n_pass++;
      if (!wr) begin
        n_checks++;
        if (t_rdata !== exp_q[0]) $display("FAIL rand_rdata: addr=%h got %h, expected %h", addr, t_rdata, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
      end
      n_checks++;
      if (t_wb_cyc !== (e_wb ? lat : 0) || t_bad !== 0)
        $display("FAIL rand_wb: addr=%h got wb_cycles=%0d proto_err=%0d, expected %0d 0",
                 addr, t_wb_cyc, t_bad, e_wb ? lat : 0);
      else n_pass++;
      if (e_wb) begin
        n_checks++;
        if (t_wb_addr !== e_wb_addr || t_wb_data !== e_wb_data)
          $display("FAIL rand_wb_line: got addr=%h data=%h, expected addr=%h data=%h",
                   t_wb_addr, t_wb_data, e_wb_addr, e_wb_data);
        else n_pass++;
      end
      if (!e_hit) begin
        n_checks++;
        if (t_fill_addr !== {addr[31:5], 5'b0})
          $display("FAIL rand_fill_addr: got %h, expected %h", t_fill_addr, {addr[31:5], 5'b0});
        else n_pass++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = '0;
    bus.mem_address = '0; bus.mem_wdata = '0; bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    test_reset();
    test_clean_miss();
    test_write_merge();
    test_dirty_evict();
    test_reset_during_fill();
    test_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1 ms, expected the run to finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/l1_cache.md
# l1_cache

Direct-mapped, write-back, write-allocate L1 cache that sits directly downstream of one `cmem_*` port of the pipelined core. One instance serves the instruction port and one serves the data port. On the core side it answers 32-bit word requests, with zero wait states on a hit. On the memory side it moves 256-bit lines to and from the shared L2 or physical memory through a request/response handshake. The `hit` output drives the core's `l1i_hit` / `l1d_hit` performance-counter inputs.

## Interface
- `SETS`, default 8: number of lines; must be a power of 2, ≥2.
  - `IDXW` = log2(`SETS`)
  - `TAGW` = 27 − `IDXW`
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `mem_read` in 1: core read request; held until `mem_resp`.
- `mem_write` in 1: core write request; held until `mem_resp`.
- `mem_byte_enable` in 4: write byte lanes.
- `mem_address` in 32: byte address; bits [1:0] ignored.
- `mem_wdata` in 32: write data.
- `mem_rdata` out 32: word `mem_address[4:2]` of the addressed line.
- `mem_resp` out 1: request complete this cycle.
- `hit` out 1: high in a `mem_resp` cycle when the request needed no line fill.
- `pmem_read` out 1: line fill request.
- `pmem_write` out 1: line writeback request.
- `pmem_address` out 32: line address, bits [4:0] = 0.
- `pmem_wdata` out 256: victim line.
- `pmem_rdata` in 256: fill line.
- `pmem_resp` in 1: memory transaction done; one-cycle pulse.

## Operation
- Storage:
  - per set: `valid`, `dirty`, tag[`TAGW`], data[256]
  - address split: tag = [31:5+`IDXW`], index = [4+`IDXW`:5], word = [4:2]
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE, no request: all outputs low; no state change.
- IDLE, request and (`valid` & tag match) — hit:
  - `mem_resp`=1 combinationally in the same cycle.
  - Read: `mem_rdata` = selected word.
  - Write: the enabled bytes of the selected word merge at the edge; `dirty` ← 1.
- IDLE, request and miss:
  - If `valid` & `dirty`: go to WRITEBACK.
  - Otherwise: go to FILL.
  - Set the internal `missed` flag.
- WRITEBACK:
  - `pmem_write`=1, `pmem_address` = {victim tag, index, 5'b0}, `pmem_wdata` = victim line.
  - On `pmem_resp`: go to FILL.
- FILL:
  - `pmem_read`=1, `pmem_address` = {req tag, index, 5'b0}.
  - On `pmem_resp`: install the line; `valid` ← 1, `dirty` ← 0, tag ← req tag; go to IDLE.
- Back in IDLE after a fill, the request now hits and completes: `mem_resp`=1, `hit`=0. `missed` clears on `mem_resp`.
- `mem_read` and `mem_write` asserted together: treated as a write.
- `mem_byte_enable` = 0 on a write: completes as a write hit with no data change; `dirty` is still set.
- Request dropped during WRITEBACK/FILL: the memory transaction finishes and the line is installed. No `mem_resp` is produced and `missed` clears.
- `pmem_read` and `pmem_write` are never high together.

## Timing
- Reset values (at the edge with `reset_n`=0, whatever the state):
  - FSM → IDLE
  - all `valid`, `dirty` and `missed` cleared
  - `pmem_read`, `pmem_write` = 0; `mem_resp`, `hit` = 0
  - tag/data arrays not cleared
- Reset during WRITEBACK/FILL abandons the transaction; memory-side strobes are low from the next cycle.
- Hit latency: 0 cycles, with `mem_resp` in the request cycle.
- Clean miss: FILL cycles until `pmem_resp`, then 1 IDLE cycle with `mem_resp`.
  - With a 1-cycle memory: `mem_resp` arrives in request cycle +2.
- Dirty miss: adds the WRITEBACK duration, +1 cycle minimum.
- `pmem_*` outputs are stable from the cycle the state is entered until the `pmem_resp` cycle inclusive.
- `pmem_rdata` is sampled only in the FILL cycle where `pmem_resp`=1.

## Configuration
- Macro: `L1_CACHE_WRITE_EN`.
- Defined: full write support as described above; used for the data-port instance.
- Undefined:
  - read-only cache for the instruction port
  - `mem_write` requests complete as a hit in IDLE with no array change
  - `dirty` is never set
  - WRITEBACK is unreachable and `pmem_write` is tied to 0

## Test plan
- After reset, read 0x0000_0040 with memory returning a line whose word 0 = 0xDEAD_BEEF after 3 cycles:
  - `pmem_read` with address 0x40 for 3 cycles
  - `mem_resp`=1, `hit`=0, `mem_rdata`=0xDEAD_BEEF one cycle after `pmem_resp`
  - re-read gives `mem_resp` in the same cycle with `hit`=1
- Write 0x1122_3344 with byte enable 4'b0101 to cached 0x44 (old 0xAABB_CCDD): the next read returns 0xAA22_CC44 and the line is dirty.
- Read 0x0000_0144 with `SETS`=8, which evicts dirty set 2:
  - `pmem_write` first, address 0x40, with the merged line
  - then `pmem_read`, address 0x140
  - then `mem_resp`
- Assert `reset_n`=0 during FILL:
  - `pmem_read` is 0 the next cycle
  - a re-read of 0x40 misses again
- Drop `mem_read` during FILL:
  - no `mem_resp`
  - a later read of the same address hits with 0 wait cycles
- Build without `L1_CACHE_WRITE_EN`:
  - a write to cached 0x44 changes nothing
  - a conflicting miss shows no `pmem_write`
